// File: rtl/lsu_issue_queue_pkg.sv
// Shared types for the LSU issue queue: uop metadata, physical register
// numbers, queue sizing constants and the queue pointer type.
package lsu_issue_queue_pkg;

  localparam int LSU_IQ_DEPTH      = 8;
  localparam int LSU_IQ_WAKE_PORTS = 4;
  localparam int PRF_W             = 6;
  localparam int ROB_IDX_W         = 7;

  typedef logic [PRF_W-1:0] PRFNum;

  typedef logic [$clog2(LSU_IQ_DEPTH)-1:0] lsu_iq_ptr_t;

  typedef struct packed {
    PRFNum op0PAddr;
    PRFNum op1PAddr;
  } Ops_Info;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] robIdx;
    logic                 isStore;
    Ops_Info              ops;
    logic                 prs1_rdy;
    logic                 prs2_rdy;
  } LSU_Queue_Meta;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] robIdx;
    logic                 valid;
  } Arbitration_Info;

endpackage

// File: rtl/lsu_iq_wakeup_match.sv
// Compares one physical register tag against every PRF wakeup broadcast
// port and flags a hit when any valid port carries that tag.
module lsu_iq_wakeup_match
  import lsu_issue_queue_pkg::*;
#(
  parameter int WAKE_PORTS = LSU_IQ_WAKE_PORTS
) (
  input  PRFNum                  tag_i,
  input  logic [WAKE_PORTS-1:0]  wake_valid_i,
  input  PRFNum [WAKE_PORTS-1:0] wake_prf_i,
  output logic                   hit_o
);

  // OR-reduce the per-port tag comparisons.
  always_comb begin
    // NOTE: combinational blocks assign a default first so no path leaves
    // the output unassigned (which would infer a latch).
    hit_o = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (wake_valid_i[p] && (wake_prf_i[p] == tag_i)) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_issue_queue.sv
// In-order load/store issue queue. Accepts up to two uops per cycle from
// dispatch, tracks source readiness through PRF wakeups and issues the head
// entry once both of its operands are ready.
// Optional feature macro: LSU_IQ_WAKEUP_BYPASS_EN -- when defined, wakeups
// arriving in the enqueue cycle also mark the incoming uops ready.
module lsu_issue_queue
  import lsu_issue_queue_pkg::*;
#(
  parameter int DEPTH      = LSU_IQ_DEPTH,
  parameter int WAKE_PORTS = LSU_IQ_WAKE_PORTS,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   enq_wen_0,
  input  logic                   enq_wen_1,
  input  LSU_Queue_Meta          enq_din_0,
  input  LSU_Queue_Meta          enq_din_1,
  input  logic [WAKE_PORTS-1:0]  wake_valid,
  input  PRFNum [WAKE_PORTS-1:0] wake_prf,
  output logic                   free_ge2,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output LSU_Queue_Meta          issue_dout,
  output logic                   empty,
  output logic [PTR_W:0]         count
);

  LSU_Queue_Meta     mem_q [DEPTH];
  logic [DEPTH-1:0]  prs1_rdy_q, prs1_rdy_d;
  logic [DEPTH-1:0]  prs2_rdy_q, prs2_rdy_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;

  logic [PTR_W-1:0]  tail_p1;
  logic [DEPTH-1:0]  hit1, hit2;
  logic              do_enq0, do_enq1, do_pop;
  logic              enq0_rdy1, enq0_rdy2, enq1_rdy1, enq1_rdy2;

  // Status outputs come only from registered state.
  assign empty       = (count_q == '0);
  assign free_ge2    = (count_q <= (PTR_W+1)'(DEPTH - 2));
  assign count       = count_q;
  assign issue_valid = !empty && prs1_rdy_q[head_q] && prs2_rdy_q[head_q];

  // Handshakes; a flush discards both the enqueue and the issue this cycle.
  // Pops are deliberately not credited toward enqueue space.
  assign do_enq0 = enq_wen_0 && free_ge2 && !flush;
  assign do_enq1 = do_enq0 && enq_wen_1;
  assign do_pop  = issue_valid && issue_ready && !flush;
  assign tail_p1 = tail_q + PTR_W'(1);

  // Wakeup comparators for every slot. Unoccupied slots may also match, which
  // is harmless because enqueue overwrites their ready bits.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    lsu_iq_wakeup_match #(.WAKE_PORTS(WAKE_PORTS)) u_match_op0 (
      .tag_i        (mem_q[e].ops.op0PAddr),
      .wake_valid_i (wake_valid),
      .wake_prf_i   (wake_prf),
      .hit_o        (hit1[e])
    );
    lsu_iq_wakeup_match #(.WAKE_PORTS(WAKE_PORTS)) u_match_op1 (
      .tag_i        (mem_q[e].ops.op1PAddr),
      .wake_valid_i (wake_valid),
      .wake_prf_i   (wake_prf),
      .hit_o        (hit2[e])
    );
  end

`ifdef LSU_IQ_WAKEUP_BYPASS_EN
  logic byp0_1, byp0_2, byp1_1, byp1_2;

  lsu_iq_wakeup_match #(.WAKE_PORTS(WAKE_PORTS)) u_byp0_op0 (
    .tag_i(enq_din_0.ops.op0PAddr), .wake_valid_i(wake_valid), .wake_prf_i(wake_prf), .hit_o(byp0_1)
  );
  lsu_iq_wakeup_match #(.WAKE_PORTS(WAKE_PORTS)) u_byp0_op1 (
    .tag_i(enq_din_0.ops.op1PAddr), .wake_valid_i(wake_valid), .wake_prf_i(wake_prf), .hit_o(byp0_2)
  );
  lsu_iq_wakeup_match #(.WAKE_PORTS(WAKE_PORTS)) u_byp1_op0 (
    .tag_i(enq_din_1.ops.op0PAddr), .wake_valid_i(wake_valid), .wake_prf_i(wake_prf), .hit_o(byp1_1)
  );
  lsu_iq_wakeup_match #(.WAKE_PORTS(WAKE_PORTS)) u_byp1_op1 (
    .tag_i(enq_din_1.ops.op1PAddr), .wake_valid_i(wake_valid), .wake_prf_i(wake_prf), .hit_o(byp1_2)
  );

  assign enq0_rdy1 = enq_din_0.prs1_rdy | byp0_1;
  assign enq0_rdy2 = enq_din_0.prs2_rdy | byp0_2;
  assign enq1_rdy1 = enq_din_1.prs1_rdy | byp1_1;
  assign enq1_rdy2 = enq_din_1.prs2_rdy | byp1_2;
`else
  // Without the bypass, a wakeup coinciding with enqueue is not captured.
  assign enq0_rdy1 = enq_din_0.prs1_rdy;
  assign enq0_rdy2 = enq_din_0.prs2_rdy;
  assign enq1_rdy1 = enq_din_1.prs1_rdy;
  assign enq1_rdy2 = enq_din_1.prs2_rdy;
`endif

  // Next-state for pointers, occupancy and per-entry ready bits.
  always_comb begin
    prs1_rdy_d = prs1_rdy_q | hit1;
    prs2_rdy_d = prs2_rdy_q | hit2;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + (PTR_W+1)'(do_enq0) + (PTR_W+1)'(do_enq1) - (PTR_W+1)'(do_pop);
    if (do_enq0) begin
      prs1_rdy_d[tail_q] = enq0_rdy1;
      prs2_rdy_d[tail_q] = enq0_rdy2;
      tail_d             = tail_p1;
    end
    if (do_enq1) begin
      prs1_rdy_d[tail_p1] = enq1_rdy1;
      prs2_rdy_d[tail_p1] = enq1_rdy2;
      tail_d              = tail_q + PTR_W'(2);
    end
    if (do_pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      prs1_rdy_q <= '0;
      prs2_rdy_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      prs1_rdy_q <= prs1_rdy_d;
      prs2_rdy_q <= prs2_rdy_d;
    end
  end

  // Payload storage, written at the tail on accepted enqueues.
  // NOTE: the payload array has no reset; occupancy and ready bits decide
  // what is visible, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_enq0) mem_q[tail_q]  <= enq_din_0;
    if (do_enq1) mem_q[tail_p1] <= enq_din_1;
  end

  // Head view with live ready bits; forced to zero while the queue is empty.
  always_comb begin
    issue_dout = '0;
    if (!empty) begin
      issue_dout          = mem_q[head_q];
      issue_dout.prs1_rdy = prs1_rdy_q[head_q];
      issue_dout.prs2_rdy = prs2_rdy_q[head_q];
    end
  end

  // Dispatch protocol checks: these writes are dropped by the queue.
  a_enq_space: assert property (@(posedge clk) disable iff (!rst_n)
                                !(enq_wen_0 && !free_ge2 && !flush))
    else $warning("lsu_issue_queue: enqueue dropped, fewer than 2 free entries");

  a_enq_order: assert property (@(posedge clk) disable iff (!rst_n)
                                !(enq_wen_1 && !enq_wen_0))
    else $warning("lsu_issue_queue: enq_wen_1 without enq_wen_0 ignored");

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Self-checking bench for lsu_issue_queue: a queue-based scoreboard holds the
// expected entries in program order and is compared at every clock.
module tb_lsu_issue_queue;
  import lsu_issue_queue_pkg::*;

  localparam int DEPTH = LSU_IQ_DEPTH;
  localparam int WP    = LSU_IQ_WAKE_PORTS;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic           enq_wen_0, enq_wen_1;
  LSU_Queue_Meta  enq_din_0, enq_din_1;
  logic [WP-1:0]  wake_valid;
  PRFNum [WP-1:0] wake_prf;
  logic           free_ge2, issue_valid, issue_ready, empty;
  LSU_Queue_Meta  issue_dout;
  logic [$clog2(DEPTH):0] count;

  int checks   = 0;
  int failures = 0;
  LSU_Queue_Meta mq[$];

  always #5 clk = ~clk;

  lsu_issue_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .enq_wen_0   (enq_wen_0),
    .enq_wen_1   (enq_wen_1),
    .enq_din_0   (enq_din_0),
    .enq_din_1   (enq_din_1),
    .wake_valid  (wake_valid),
    .wake_prf    (wake_prf),
    .free_ge2    (free_ge2),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_dout  (issue_dout),
    .empty       (empty),
    .count       (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic LSU_Queue_Meta mk(input int id, input bit st, input int p0, input int p1,
                                       input bit r1, input bit r2);
    LSU_Queue_Meta m;
    m.robIdx       = ROB_IDX_W'(id);
    m.isStore      = st;
    m.ops.op0PAddr = PRF_W'(p0);
    m.ops.op1PAddr = PRF_W'(p1);
    m.prs1_rdy     = r1;
    m.prs2_rdy     = r2;
    return m;
  endfunction

  function automatic LSU_Queue_Meta woke(input LSU_Queue_Meta m);
    LSU_Queue_Meta r = m;
    for (int p = 0; p < WP; p++) begin
      if (wake_valid[p] && wake_prf[p] == m.ops.op0PAddr) r.prs1_rdy = 1'b1;
      if (wake_valid[p] && wake_prf[p] == m.ops.op1PAddr) r.prs2_rdy = 1'b1;
    end
    return r;
  endfunction

  function automatic LSU_Queue_Meta enq_view(input LSU_Queue_Meta m);
`ifdef LSU_IQ_WAKEUP_BYPASS_EN
    return woke(m);
`else
    return m;
`endif
  endfunction

  task automatic idle();
    flush       = 1'b0;
    enq_wen_0   = 1'b0;
    enq_wen_1   = 1'b0;
    enq_din_0   = '0;
    enq_din_1   = '0;
    wake_valid  = '0;
    wake_prf    = '0;
    issue_ready = 1'b0;
  endtask

  // Compare pre-edge outputs, advance the scoreboard, clock once, compare
  // the post-edge status. Called with inputs already set after a negedge.
  task automatic tick();
    bit hv;
    int free;
    hv = (mq.size() > 0) && mq[0].prs1_rdy && mq[0].prs2_rdy;
    check("issue_valid", 64'(issue_valid), 64'(hv));
    if (hv && issue_ready) check("issue_dout", 64'(issue_dout), 64'(mq[0]));
    if (mq.size() == 0) check("dout_empty", 64'(issue_dout), 64'd0);
    free = DEPTH - mq.size();
    if (flush) begin
      mq.delete();
    end else begin
      foreach (mq[k]) mq[k] = woke(mq[k]);
      if (hv && issue_ready) void'(mq.pop_front());
      if (enq_wen_0 && free >= 2) begin
        mq.push_back(enq_view(enq_din_0));
        if (enq_wen_1) mq.push_back(enq_view(enq_din_1));
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("count", 64'(count), 64'(mq.size()));
    check("empty", 64'(empty), 64'(mq.size() == 0));
    check("free_ge2", 64'(free_ge2), 64'((DEPTH - mq.size()) >= 2));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_empty"}, 64'(empty), 64'd1);
    check({tag, "_free_ge2"}, 64'(free_ge2), 64'd1);
    check({tag, "_issue_valid"}, 64'(issue_valid), 64'd0);
    check({tag, "_issue_dout"}, 64'(issue_dout), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single ready uop: visible the next cycle, gone after the handshake.
    enq_wen_0 = 1'b1; enq_din_0 = mk(1, 0, 3, 4, 1, 1);
    tick();
    idle(); issue_ready = 1'b1;
    tick();

    // Not-ready older load blocks a ready younger one until its wakeup.
    idle();
    enq_wen_0 = 1'b1; enq_wen_1 = 1'b1;
    enq_din_0 = mk(2, 0, 17, 5, 0, 1);
    enq_din_1 = mk(3, 0, 6, 7, 1, 1);
    issue_ready = 1'b1;
    tick();
    idle(); issue_ready = 1'b1;
    tick();
    idle(); issue_ready = 1'b1; wake_valid[2] = 1'b1; wake_prf[2] = PRF_W'(17);
    tick();
    idle(); issue_ready = 1'b1;
    tick();
    tick();

    // Fill toward full with the LSU stalled, then exercise drop and full+pop.
    for (int i = 0; i < 3; i++) begin
      idle(); enq_wen_0 = 1'b1; enq_wen_1 = 1'b1;
      enq_din_0 = mk(10 + 2 * i, 0, 8, 9, 1, 1);
      enq_din_1 = mk(11 + 2 * i, 1, 8, 9, 1, 1);
      tick();
    end
    idle(); enq_wen_0 = 1'b1; enq_din_0 = mk(16, 0, 1, 2, 1, 1);
    tick();
    idle(); enq_wen_0 = 1'b1; enq_din_0 = mk(17, 0, 1, 2, 1, 1);
    tick();
    idle(); issue_ready = 1'b1;
    tick();
    idle(); enq_wen_0 = 1'b1; enq_wen_1 = 1'b1;
    enq_din_0 = mk(18, 1, 1, 2, 1, 1);
    enq_din_1 = mk(19, 0, 1, 2, 1, 1);
    tick();
    idle(); enq_wen_0 = 1'b1; enq_din_0 = mk(20, 0, 1, 2, 1, 1); issue_ready = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      idle(); issue_ready = 1'b1;
      tick();
    end

    // Wrap-around: paired enqueue/issue so the pointers cross the end.
    for (int i = 0; i < 20; i++) begin
      idle(); enq_wen_0 = 1'b1; enq_din_0 = mk(32 + i, i % 2, i, i + 1, 1, 1);
      issue_ready = 1'b1;
      tick();
    end
    idle(); issue_ready = 1'b1;
    tick();

    // Flush with a same-cycle enqueue and issue handshake.
    for (int i = 0; i < 5; i++) begin
      idle(); enq_wen_0 = 1'b1; enq_din_0 = mk(60 + i, 0, 2, 3, 1, 1);
      tick();
    end
    idle(); flush = 1'b1; enq_wen_0 = 1'b1; enq_din_0 = mk(65, 0, 2, 3, 1, 1);
    issue_ready = 1'b1;
    tick();
    idle(); enq_wen_0 = 1'b1; enq_din_0 = mk(66, 1, 2, 3, 1, 1);
    tick();
    idle(); issue_ready = 1'b1;
    tick();

    // Randomised traffic with wakeups and back-pressure.
    for (int i = 0; i < 80; i++) begin
      idle();
      if ((DEPTH - mq.size()) >= 2 && $urandom_range(0, 2) != 0) begin
        enq_wen_0 = 1'b1;
        enq_din_0 = mk(i, $urandom_range(0, 1), $urandom_range(1, 15), $urandom_range(1, 15),
                       $urandom_range(0, 1), $urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
          enq_wen_1 = 1'b1;
          enq_din_1 = mk(i + 64, $urandom_range(0, 1), $urandom_range(1, 15), $urandom_range(1, 15),
                         $urandom_range(0, 1), $urandom_range(0, 1));
        end
      end
      for (int p = 0; p < WP; p++) begin
        wake_valid[p] = ($urandom_range(0, 3) == 0);
        wake_prf[p]   = PRF_W'($urandom_range(1, 15));
      end
      issue_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      idle();
      for (int p = 0; p < WP; p++) begin
        wake_valid[p] = 1'b1;
        wake_prf[p]   = PRF_W'(1 + 4 * p + (i % 4));
      end
      issue_ready = 1'b1;
      tick();
    end

    // Asynchronous reset with entries in flight.
    idle(); enq_wen_0 = 1'b1; enq_wen_1 = 1'b1;
    enq_din_0 = mk(70, 0, 4, 5, 1, 1);
    enq_din_1 = mk(71, 1, 4, 5, 1, 1);
    tick();
    idle(); enq_wen_0 = 1'b1; enq_din_0 = mk(72, 0, 4, 5, 1, 1);
    tick();
    idle();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    enq_wen_0 = 1'b1; enq_din_0 = mk(73, 1, 6, 7, 1, 1);
    tick();
    idle(); issue_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
